// File: rtl/down245m_to_122m.sv
// Half-band 2:1 decimator, 245.76 -> 122.88 MSPS: 11-tap symmetric FIR with
// run-time coefficients, ca-aligned sample pairing and a fixed 4-cycle pipeline.
module down245m_to_122m (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_data_vld,
    input  logic        i_data_ca,
    input  logic [15:0] i_data,
    input  logic        i_coef_wr,
    input  logic [1:0]  i_coef_addr,
    input  logic [15:0] i_coef_data,
    output logic        o_data_vld,
    output logic        o_data_ca,
    output logic [15:0] o_data,
    output logic        o_sat
);

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int PRE_W  = DATA_W + 1;
    localparam int PROD_W = PRE_W + COEF_W;
    localparam int SUM_W  = PROD_W + 2;
    localparam int FRAC   = COEF_W - 1;
    localparam int RND_W  = SUM_W - FRAC;

    localparam logic signed [COEF_W-1:0] C0_DEF = 16'sd324;
    localparam logic signed [COEF_W-1:0] C1_DEF = -16'sd1878;
    localparam logic signed [COEF_W-1:0] C2_DEF = 16'sd9745;
    localparam logic signed [COEF_W-1:0] CC_DEF = 16'sd16384;

    localparam logic signed [SUM_W-1:0] HALF_LSB =
        {{(SUM_W - FRAC){1'b0}}, 1'b1, {(FRAC - 1){1'b0}}};
    localparam logic signed [RND_W-1:0] SAT_HI = RND_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [RND_W-1:0] SAT_LO = -RND_W'(2 ** (DATA_W - 1));

    function automatic logic signed [PRE_W-1:0] pre_add(input logic [DATA_W-1:0] a,
                                                        input logic [DATA_W-1:0] b);
        return $signed({a[DATA_W-1], a}) + $signed({b[DATA_W-1], b});
    endfunction

    function automatic logic signed [PROD_W-1:0] mul(input logic signed [PRE_W-1:0]  a,
                                                     input logic signed [COEF_W-1:0] c);
        return PROD_W'(a) * PROD_W'(c);
    endfunction

    // Round half up: add half an LSB of the Q1.15 result, then drop the fraction.
    function automatic logic signed [RND_W-1:0] round_q15(input logic signed [SUM_W-1:0] s);
        return RND_W'((s + HALF_LSB) >>> FRAC);
    endfunction

    // Returns {clipped, value}.
    function automatic logic [DATA_W:0] saturate(input logic signed [RND_W-1:0] v);
        if (v > SAT_HI) begin
            return {1'b1, SAT_HI[DATA_W-1:0]};
        end else if (v < SAT_LO) begin
            return {1'b1, SAT_LO[DATA_W-1:0]};
        end
        return {1'b0, v[DATA_W-1:0]};
    endfunction

    logic signed [COEF_W-1:0] c0, c1, c2, cc;

    logic [10:0][DATA_W-1:0] x;
    logic                    phase;
    logic                    pair_ca;

    logic vld_p0, vld_p1, vld_p2, vld_p3;
    logic ca_p0, ca_p1, ca_p2, ca_p3;

    logic signed [PRE_W-1:0]  pre0_p1, pre1_p1, pre2_p1;
    logic signed [DATA_W-1:0] mid_p1;
    logic signed [PROD_W-1:0] prod0_p2, prod1_p2, prod2_p2, prod3_p2;
    logic signed [RND_W-1:0]  rnd_p3;
    logic [DATA_W:0]          sat_res;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            c0 <= C0_DEF;
            c1 <= C1_DEF;
            c2 <= C2_DEF;
            cc <= CC_DEF;
        end else if (i_coef_wr) begin
            case (i_coef_addr)
                2'd0:    c0 <= $signed(i_coef_data);
                2'd1:    c1 <= $signed(i_coef_data);
                2'd2:    c2 <= $signed(i_coef_data);
                default: cc <= $signed(i_coef_data);
            endcase
        end
    end

    // S0: delay line, pair phase and launch of a completed pair.
    // A ca sample always opens a new pair, dropping any half pair in progress.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            x       <= '0;
            phase   <= 1'b0;
            pair_ca <= 1'b0;
            vld_p0  <= 1'b0;
            ca_p0   <= 1'b0;
            vld_p1  <= 1'b0;
            ca_p1   <= 1'b0;
            vld_p2  <= 1'b0;
            ca_p2   <= 1'b0;
            vld_p3  <= 1'b0;
            ca_p3   <= 1'b0;
        end else begin
            vld_p0 <= i_data_vld & phase & ~i_data_ca;
            ca_p0  <= i_data_vld & phase & ~i_data_ca & pair_ca;
            if (i_data_vld) begin
                x       <= {x[9:0], i_data};
                phase   <= i_data_ca | ~phase;
                pair_ca <= i_data_ca | (phase & pair_ca);
            end
            vld_p1 <= vld_p0;
            ca_p1  <= ca_p0;
            vld_p2 <= vld_p1;
            ca_p2  <= ca_p1;
            vld_p3 <= vld_p2;
            ca_p3  <= ca_p2;
        end
    end

    // S1: symmetric pre-add; odd taps carry zero coefficients and are skipped.
    always_ff @(posedge i_clk) begin
        if (vld_p0) begin
            pre0_p1 <= pre_add(x[0], x[10]);
            pre1_p1 <= pre_add(x[2], x[8]);
            pre2_p1 <= pre_add(x[4], x[6]);
            mid_p1  <= $signed(x[5]);
        end
    end

    // S2: multiply against the coefficient registers as they stand now.
    always_ff @(posedge i_clk) begin
        if (vld_p1) begin
            prod0_p2 <= mul(pre0_p1, c0);
            prod1_p2 <= mul(pre1_p1, c1);
            prod2_p2 <= mul(pre2_p1, c2);
            prod3_p2 <= mul(PRE_W'(mid_p1), cc);
        end
    end

    // S3: accumulate and round.
    always_ff @(posedge i_clk) begin
        if (vld_p2) begin
            rnd_p3 <= round_q15(SUM_W'(prod0_p2) + SUM_W'(prod1_p2)
                              + SUM_W'(prod2_p2) + SUM_W'(prod3_p2));
        end
    end

    // S4: saturate and register the outputs.
    assign sat_res = saturate(rnd_p3);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_data_vld <= 1'b0;
            o_data_ca  <= 1'b0;
            o_data     <= '0;
            o_sat      <= 1'b0;
        end else begin
            o_data_vld <= vld_p3;
            o_data_ca  <= vld_p3 & ca_p3;
            o_sat      <= vld_p3 & sat_res[DATA_W];
            if (vld_p3) begin
                o_data <= sat_res[DATA_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_down245m_to_122m.sv
// Bench for the 2:1 half-band decimator: directed cases plus random traffic
// checked cycle by cycle against a sample-history reference model.
module tb_down245m_to_122m;

    logic               i_clk       = 1'b0;
    logic               i_rst       = 1'b0;
    logic               i_data_vld  = 1'b0;
    logic               i_data_ca   = 1'b0;
    logic [15:0]        i_data      = '0;
    logic               i_coef_wr   = 1'b0;
    logic [1:0]         i_coef_addr = '0;
    logic [15:0]        i_coef_data = '0;
    logic               o_data_vld;
    logic               o_data_ca;
    logic signed [15:0] o_data;
    logic               o_sat;

    down245m_to_122m dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_data_vld  (i_data_vld),
        .i_data_ca   (i_data_ca),
        .i_data      (i_data),
        .i_coef_wr   (i_coef_wr),
        .i_coef_addr (i_coef_addr),
        .i_coef_data (i_coef_data),
        .o_data_vld  (o_data_vld),
        .o_data_ca   (o_data_ca),
        .o_data      (o_data),
        .o_sat       (o_sat)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: full sample history since reset, a per-frame sample
    // count, and a log of coefficient writes tagged with their clock edge.
    typedef struct packed {
        logic [10:0][15:0] win;
        logic              ca;
        int                t;
    } launch_t;

    typedef struct packed {
        int e;
        int a;
        int d;
    } cwr_t;

    launch_t            pend[$];
    cwr_t               wq[$];
    logic signed [15:0] hist[$];
    int                 cyc  = 0;
    int                 fcnt = 0;
    bit                 fca  = 1'b0;
    int                 mc[4];

    logic signed [15:0] obs_d[$];
    bit                 obs_ca[$];
    bit                 obs_sat[$];

    function automatic void model_clear();
        pend.delete();
        wq.delete();
        hist.delete();
        fcnt = 0;
        fca  = 1'b0;
        mc   = '{324, -1878, 9745, 16384};
    endfunction

    function automatic longint tap(input launch_t l, input int j);
        return longint'($signed(l.win[j]));
    endfunction

    always @(negedge i_rst) model_clear();

    always @(posedge i_clk) begin : model_step
        launch_t lw;
        cyc++;
        if (i_rst) begin
            if (i_coef_wr)
                wq.push_back('{cyc, int'(i_coef_addr), int'($signed(i_coef_data))});
            if (i_data_vld) begin
                hist.push_back($signed(i_data));
                if (i_data_ca) begin
                    fcnt = 1;
                    fca  = 1'b1;
                end else begin
                    fcnt++;
                end
                if (fcnt % 2 == 0) begin
                    for (int j = 0; j < 11; j++)
                        lw.win[j] = (hist.size() > j) ? hist[hist.size() - 1 - j] : 16'sd0;
                    lw.ca = fca && (fcnt == 2);
                    lw.t  = cyc;
                    pend.push_back(lw);
                end
            end
        end
    end

    always @(negedge i_clk) begin : monitor
        launch_t l;
        longint  y, r;
        bit      s;
        if (pend.size() > 0 && pend[0].t + 4 == cyc) begin
            l = pend.pop_front();
            // Multiply happens two edges after launch: writes before that edge apply.
            while (wq.size() > 0 && wq[0].e < l.t + 2) begin
                mc[wq[0].a] = wq[0].d;
                void'(wq.pop_front());
            end
            y = mc[0] * (tap(l, 0) + tap(l, 10)) + mc[1] * (tap(l, 2) + tap(l, 8))
              + mc[2] * (tap(l, 4) + tap(l, 6)) + mc[3] * tap(l, 5);
            r = (y + 16384) >>> 15;
            s = 1'b0;
            if (r > 32767) begin
                r = 32767;
                s = 1'b1;
            end else if (r < -32768) begin
                r = -32768;
                s = 1'b1;
            end
            chk("out_vld", o_data_vld, 1);
            chk("out_data", o_data, r);
            chk("out_ca", o_data_ca, l.ca);
            chk("out_sat", o_sat, s);
        end else begin
            chk("idle_vld", o_data_vld, 0);
            chk("idle_sat", o_sat, 0);
        end
        if (o_data_vld === 1'b1) begin
            obs_d.push_back(o_data);
            obs_ca.push_back(o_data_ca);
            obs_sat.push_back(o_sat);
        end
    end

    function automatic logic signed [15:0] obs_at(input int k);
        return (k < obs_d.size()) ? obs_d[k] : 16'bx;
    endfunction

    task automatic cyc_in(input bit v, input bit c, input int d,
                          input bit w = 1'b0, input int a = 0, input int cd = 0);
        i_data_vld  = v;
        i_data_ca   = c;
        i_data      = 16'(d);
        i_coef_wr   = w;
        i_coef_addr = 2'(a);
        i_coef_data = 16'(cd);
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc_in(1'b0, 1'b0, 0);
    endtask

    task automatic do_reset();
        i_rst = 1'b0;
        idle(3);
        i_rst = 1'b1;
    endtask

    task automatic clr_obs();
        obs_d.delete();
        obs_ca.delete();
        obs_sat.delete();
    endtask

    task automatic dc_run(input string tag);
        clr_obs();
        for (int i = 0; i < 40; i++) cyc_in(1'b1, i == 0, 1000);
        idle(8);
        chk({tag, "_count"}, obs_d.size(), 20);
        for (int k = 5; k < 20; k++) chk({tag, "_data"}, obs_at(k), 1000);
    endtask

    int ev[12] = '{162, -939, 4873, 4873, -939, 162, 0, 0, 0, 0, 0, 0};

    initial begin
        model_clear();
        @(posedge i_clk);
        #1;
        chk("rst_vld", o_data_vld, 0);
        chk("rst_ca", o_data_ca, 0);
        chk("rst_data", o_data, 0);
        chk("rst_sat", o_sat, 0);
        idle(2);
        i_rst = 1'b1;
        idle(2);

        dc_run("dc");

        // Impulse on the phase-0 sample: only the centre tap ever sees it.
        do_reset();
        clr_obs();
        for (int i = 0; i < 24; i++) cyc_in(1'b1, i == 0, (i == 0) ? 16384 : 0);
        idle(8);
        chk("imp_odd_count", obs_d.size(), 12);
        chk("imp_odd_ca", (obs_ca.size() > 0) ? obs_ca[0] : 1'b0, 1);
        for (int k = 0; k < 12; k++) chk("imp_odd", obs_at(k), (k == 2) ? 8192 : 0);

        // Impulse on the phase-1 sample walks through the even taps.
        do_reset();
        clr_obs();
        for (int i = 0; i < 24; i++) cyc_in(1'b1, i == 0, (i == 1) ? 16384 : 0);
        idle(8);
        chk("imp_even_count", obs_d.size(), 12);
        for (int k = 0; k < 12; k++) chk("imp_even", obs_at(k), ev[k]);

        // Saturation, with a coefficient write landing on the ca cycle.
        do_reset();
        clr_obs();
        cyc_in(1'b0, 1'b0, 0, 1'b1, 3, 32767);
        cyc_in(1'b1, 1'b1, 32767, 1'b1, 2, 32767);
        for (int i = 0; i < 23; i++) cyc_in(1'b1, 1'b0, 32767);
        idle(8);
        chk("sat_pos", obs_at(obs_d.size() - 1), 32767);
        chk("sat_pos_flag", (obs_sat.size() > 0) ? obs_sat[obs_sat.size() - 1] : 1'b0, 1);
        clr_obs();
        for (int i = 0; i < 24; i++) cyc_in(1'b1, 1'b0, -32768);
        idle(8);
        chk("sat_neg", obs_at(obs_d.size() - 1), -32768);
        chk("sat_neg_flag", (obs_sat.size() > 0) ? obs_sat[obs_sat.size() - 1] : 1'b0, 1);

        // Gapped input with a ca on a phase-1 sample: orphan s2 is dropped.
        do_reset();
        clr_obs();
        for (int i = 0; i < 7; i++) begin
            cyc_in(1'b1, (i == 0) || (i == 3), $urandom_range(0, 65535));
            idle(1);
        end
        idle(8);
        chk("gap_count", obs_d.size(), 3);
        chk("gap_ca0", (obs_ca.size() > 0) ? obs_ca[0] : 1'b0, 1);
        chk("gap_ca1", (obs_ca.size() > 1) ? obs_ca[1] : 1'b0, 1);
        chk("gap_ca2", (obs_ca.size() > 2) ? obs_ca[2] : 1'b1, 0);

        // Reset with two results in flight; coefficients must return to defaults.
        do_reset();
        clr_obs();
        for (int i = 0; i < 20; i++) cyc_in(1'b1, i == 0, $urandom_range(0, 65535));
        idle(1);
        i_rst = 1'b0;
        idle(3);
        i_rst = 1'b1;
        idle(8);
        chk("rst_mid_count", obs_d.size(), 8);
        dc_run("dc_after_rst");

        // Random traffic: gaps, ca markers and coefficient writes at any time.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc_in($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                   $urandom_range(0, 65535), $urandom_range(0, 24) == 0,
                   $urandom_range(0, 3), $urandom_range(0, 65535));
        end
        idle(8);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
